tx_framer: RTL and testbench

- Downstream neighbour of the tx cipher stage. Consumes the 32-bit enciphered AXI-Stream and packs it into fixed-length frames for the link.
- Frame layout: sync word, sequence/length word, C_PAYLOAD_WORDS payload words, then a checksum trailer with tlast.
- Registered AXI-Stream master output with full backpressure. Status counters are exposed for the AXI-Lite register block.

---
 rtl/tx_framer.sv | 143 ++++++++++++++
 tb/tb_tx_framer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framer.sv
// Frame packer for the enciphered tx stream: sync word, sequence/length word,
// C_PAYLOAD_WORDS payload words and a checksum trailer carrying tlast.
module tx_framer #(
    parameter int unsigned  C_PAYLOAD_WORDS = 16,
    parameter logic [31:0]  C_SYNC_WORD     = 32'hA5A5_5A5A
) (
    input  logic        i_aclk,
    input  logic        i_aresetn,
    input  logic        i_enable,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_sof,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [31:0] o_frame_count,
    output logic        o_sof_error,
    output logic        o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEQ,
        ST_PAYLOAD,
        ST_TRAILER
    } state_t;

    localparam logic [15:0] FRAME_LEN = 16'(C_PAYLOAD_WORDS);
    localparam logic [15:0] LAST_IDX  = 16'(C_PAYLOAD_WORDS - 1);

    state_t      state_reg, state_next;
    logic        tvalid_reg, tvalid_next;
    logic [31:0] tdata_reg, tdata_next;
    logic        tlast_reg, tlast_next;
    logic [15:0] seq_reg, seq_next;
    logic [15:0] idx_reg, idx_next;
    logic [31:0] csum_reg, csum_next;
    logic [31:0] count_reg, count_next;
    logic        sof_err_reg, sof_err_next;
    logic        load;

    // The output register may take a new word whenever it is empty or draining.
    assign load          = !tvalid_reg || m_axis_tready;
    assign s_axis_tready = (state_reg == ST_PAYLOAD) && load;

    assign m_axis_tvalid = tvalid_reg;
    assign m_axis_tdata  = tdata_reg;
    assign m_axis_tlast  = tlast_reg;
    assign o_frame_count = count_reg;
    assign o_sof_error   = sof_err_reg;
    assign o_busy        = (state_reg != ST_IDLE);

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_reg   <= ST_IDLE;
            tvalid_reg  <= 1'b0;
            tdata_reg   <= 32'd0;
            tlast_reg   <= 1'b0;
            seq_reg     <= 16'd0;
            idx_reg     <= 16'd0;
            csum_reg    <= 32'd0;
            count_reg   <= 32'd0;
            sof_err_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tvalid_reg  <= tvalid_next;
            tdata_reg   <= tdata_next;
            tlast_reg   <= tlast_next;
            seq_reg     <= seq_next;
            idx_reg     <= idx_next;
            csum_reg    <= csum_next;
            count_reg   <= count_next;
            sof_err_reg <= sof_err_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tvalid_next  = tvalid_reg;
        tdata_next   = tdata_reg;
        tlast_next   = tlast_reg;
        seq_next     = seq_reg;
        idx_next     = idx_reg;
        csum_next    = csum_reg;
        count_next   = count_reg;
        sof_err_next = sof_err_reg;

        if (load) begin
            tlast_next = 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    // Start only when payload is already waiting, so the
                    // frame header is never emitted ahead of its data.
                    if (i_enable && s_axis_tvalid) begin
                        tvalid_next = 1'b1;
                        tdata_next  = C_SYNC_WORD;
                        state_next  = ST_SEQ;
                    end else begin
                        tvalid_next = 1'b0;
                    end
                end
                ST_SEQ: begin
                    tvalid_next = 1'b1;
                    tdata_next  = {seq_reg, FRAME_LEN};
                    csum_next   = 32'd0;
                    idx_next    = 16'd0;
                    state_next  = ST_PAYLOAD;
                end
                ST_PAYLOAD: begin
                    if (s_axis_tvalid) begin
                        tvalid_next = 1'b1;
                        tdata_next  = s_axis_tdata;
                        csum_next   = csum_reg + s_axis_tdata;
                        idx_next    = idx_reg + 16'd1;
                        if (s_axis_sof && (idx_reg != 16'd0)) begin
                            sof_err_next = 1'b1;
                        end
                        if (idx_reg == LAST_IDX) begin
                            state_next = ST_TRAILER;
                        end
                    end else begin
                        tvalid_next = 1'b0;
                    end
                end
                ST_TRAILER: begin
                    tvalid_next = 1'b1;
                    tdata_next  = csum_reg;
                    tlast_next  = 1'b1;
                    seq_next    = seq_reg + 16'd1;
                    count_next  = count_reg + 32'd1;
                    state_next  = ST_IDLE;
                end
                default: begin
                    state_next  = ST_IDLE;
                    tvalid_next = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_framer.sv
// Self-checking bench for tx_framer: table of payload frames with expected
// checksums, scoreboard of expected output beats, plus hand-written corner cases.
module tb_tx_framer;

    localparam int          PW   = 4;
    localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

    logic        i_aclk;
    logic        i_aresetn;
    logic        i_enable;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata;
    logic        s_axis_sof;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [31:0] o_frame_count;
    logic        o_sof_error;
    logic        o_busy;

    tx_framer #(
        .C_PAYLOAD_WORDS(PW),
        .C_SYNC_WORD    (SYNC)
    ) dut (
        .i_aclk        (i_aclk),
        .i_aresetn     (i_aresetn),
        .i_enable      (i_enable),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_sof    (s_axis_sof),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .o_frame_count (o_frame_count),
        .o_sof_error   (o_sof_error),
        .o_busy        (o_busy)
    );

    initial i_aclk = 1'b0;
    always #5 i_aclk = ~i_aclk;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
        logic        first;
    } beat_t;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
    } src_t;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [31:0]      trailer;
    } vec_t;

    vec_t        tbl [4];
    beat_t       exp_q [$];
    src_t        src_q [$];
    int          gaps [$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          tlast_cyc = 0;
    bit          have_tlast = 0;
    bit          s_take = 0;
    int          s_beats = 0;
    bit          bp_mode = 0;
    bit          prev_stall = 0;
    logic [31:0] prev_data = 32'd0;
    logic        prev_last = 1'b0;
    logic [15:0] exp_seq = 16'd0;
    int          exp_frames = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %08h required %08h", name, act, req);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] c, input logic [31:0] d, input logic [31:0] t);
        tbl[i].w[0]    = a;
        tbl[i].w[1]    = b;
        tbl[i].w[2]    = c;
        tbl[i].w[3]    = d;
        tbl[i].trailer = t;
    endtask

    task automatic push_src(input int i, input logic [3:0] sof);
        for (int k = 0; k < PW; k++) src_q.push_back('{tbl[i].w[k], sof[k]});
    endtask

    task automatic push_exp(input int i);
        exp_q.push_back('{SYNC, 1'b0, 1'b1});
        exp_q.push_back('{{exp_seq, 16'(PW)}, 1'b0, 1'b0});
        for (int k = 0; k < PW; k++) exp_q.push_back('{tbl[i].w[k], 1'b0, 1'b0});
        exp_q.push_back('{tbl[i].trailer, 1'b1, 1'b0});
        exp_seq = exp_seq + 16'd1;
        exp_frames++;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || src_q.size() != 0 || m_axis_tvalid) && n < 500) begin
            @(negedge i_aclk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL drain_%s: got %0d beats outstanding required 0", name, exp_q.size());
        end
    endtask

    task automatic wait_beats(input string name, input int target);
        int n = 0;
        while (s_beats < target && n < 500) begin
            @(negedge i_aclk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL beats_%s: got %0d input beats required %0d", name, s_beats, target);
        end
    endtask

    // Monitor: everything sampled on the falling edge, mid-cycle.
    initial begin
        beat_t e;
        forever begin
            @(negedge i_aclk);
            cyc++;
            s_take = s_axis_tvalid && s_axis_tready;
            if (s_take) s_beats++;
            if (i_aresetn) begin
                if (prev_stall) begin
                    check("hold_valid", {31'd0, m_axis_tvalid}, 32'd1);
                    check("hold_data", m_axis_tdata, prev_data);
                    check("hold_last", {31'd0, m_axis_tlast}, {31'd0, prev_last});
                end
                if (m_axis_tvalid && !m_axis_tready)
                    check("stall_s_tready", {31'd0, s_axis_tready}, 32'd0);
                prev_stall = m_axis_tvalid && !m_axis_tready;
                prev_data  = m_axis_tdata;
                prev_last  = m_axis_tlast;
                if (m_axis_tvalid && m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got %08h required no beat", m_axis_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_data", m_axis_tdata, e.data);
                        check("beat_last", {31'd0, m_axis_tlast}, {31'd0, e.last});
                        if (e.first && have_tlast) gaps.push_back(cyc - tlast_cyc);
                        if (m_axis_tlast) begin
                            have_tlast = 1;
                            tlast_cyc  = cyc;
                        end
                    end
                end
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Source and sink driver: inputs change just after the rising edge.
    initial begin
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = 32'd0;
        s_axis_sof    = 1'b0;
        m_axis_tready = 1'b1;
        forever begin
            @(posedge i_aclk);
            #1;
            if (s_take && src_q.size() > 0) src_q.delete(0);
            if (src_q.size() > 0) begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata  = src_q[0].data;
                s_axis_sof    = src_q[0].sof;
            end else begin
                s_axis_tvalid = 1'b0;
                s_axis_tdata  = 32'd0;
                s_axis_sof    = 1'b0;
            end
            m_axis_tready = bp_mode ? ~m_axis_tready : 1'b1;
        end
    end

    initial begin
        int base;
        i_aresetn = 1'b0;
        i_enable  = 1'b0;
        set_vec(0, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0004, 32'h0000_000A);
        set_vec(1, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001);
        set_vec(2, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 32'h0000_0040, 32'h0000_00A0);
        set_vec(3, 32'h8000_0000, 32'h8000_0001, 32'h0000_0007, 32'hDEAD_BEEF, 32'hDEAD_BEF7);

        repeat (3) @(negedge i_aclk);
        check("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("rst_m_tdata", m_axis_tdata, 32'd0);
        check("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        check("rst_frame_count", o_frame_count, 32'd0);
        check("rst_sof_error", {31'd0, o_sof_error}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        i_aresetn = 1'b1;
        @(negedge i_aclk);

        // Whole table back to back at full rate.
        i_enable = 1'b1;
        gaps.delete();
        for (int i = 0; i < 4; i++) begin
            push_src(i, 4'b0001);
            push_exp(i);
        end
        wait_drain("table");
        check("table_frame_count", o_frame_count, 32'(exp_frames));
        check("table_busy", {31'd0, o_busy}, 32'd0);
        check("table_gap_count", 32'(gaps.size()), 32'd3);
        foreach (gaps[g]) check("table_frame_gap", 32'(gaps[g]), 32'd1);

        // Downstream ready toggling every cycle.
        bp_mode = 1;
        push_src(0, 4'b0001);
        push_exp(0);
        push_src(1, 4'b0000);
        push_exp(1);
        wait_drain("backpressure");
        bp_mode = 0;
        @(negedge i_aclk);
        check("bp_frame_count", o_frame_count, 32'(exp_frames));

        // Misplaced start-of-frame marker is sticky; one on index 0 is benign.
        check("sof_before", {31'd0, o_sof_error}, 32'd0);
        push_src(2, 4'b0100);
        push_exp(2);
        wait_drain("sof_bad");
        check("sof_set", {31'd0, o_sof_error}, 32'd1);
        push_src(3, 4'b0001);
        push_exp(3);
        wait_drain("sof_ok");
        check("sof_sticky", {31'd0, o_sof_error}, 32'd1);
        check("sof_frame_count", o_frame_count, 32'(exp_frames));

        // Dropping enable mid-frame lets the frame finish but blocks the next.
        base = s_beats;
        push_src(0, 4'b0001);
        push_exp(0);
        wait_beats("disable", base + 2);
        i_enable = 1'b0;
        wait_drain("disable");
        check("dis_busy", {31'd0, o_busy}, 32'd0);
        check("dis_frame_count", o_frame_count, 32'(exp_frames));
        push_src(1, 4'b0001);
        repeat (20) @(negedge i_aclk);
        check("dis_idle_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("dis_idle_busy", {31'd0, o_busy}, 32'd0);
        check("dis_no_consume", 32'(src_q.size()), 32'(PW));
        i_enable = 1'b1;
        push_exp(1);
        wait_drain("reenable");
        check("reen_frame_count", o_frame_count, 32'(exp_frames));

        // Reset in the middle of the payload.
        base = s_beats;
        push_src(2, 4'b0001);
        push_exp(2);
        wait_beats("reset", base + 2);
        @(negedge i_aclk);
        i_aresetn = 1'b0;
        #1;
        check("mid_rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
        check("mid_rst_m_tdata", m_axis_tdata, 32'd0);
        check("mid_rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
        check("mid_rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
        check("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        check("mid_rst_frame_count", o_frame_count, 32'd0);
        check("mid_rst_sof_error", {31'd0, o_sof_error}, 32'd0);
        src_q.delete();
        exp_q.delete();
        repeat (3) @(negedge i_aclk);
        i_aresetn  = 1'b1;
        exp_seq    = 16'd0;
        exp_frames = 0;
        have_tlast = 0;
        push_src(3, 4'b0001);
        push_exp(3);
        wait_drain("after_reset");
        check("post_rst_frame_count", o_frame_count, 32'(exp_frames));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
